// File: rtl/dvp_config_master_if.sv
// rtl/dvp_config_master_if.sv - AXI4 single-beat bus between the DVP config master and the register slave
interface dvp_config_master_if #(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 32,
  parameter int MST_ID_W     = 5,
  parameter int TRANS_RESP_W = 2
);
  logic [MST_ID_W-1:0]     awid;
  logic [ADDR_W-1:0]       awaddr;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_W-1:0]       wdata;
  logic                    wvalid;
  logic                    wready;
  logic [MST_ID_W-1:0]     bid;
  logic [TRANS_RESP_W-1:0] bresp;
  logic                    bvalid;
  logic                    bready;
  logic [MST_ID_W-1:0]     arid;
  logic [ADDR_W-1:0]       araddr;
  logic                    arvalid;
  logic                    arready;
  logic [MST_ID_W-1:0]     rid;
  logic [DATA_W-1:0]       rdata;
  logic [TRANS_RESP_W-1:0] rresp;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awid, awaddr, awvalid, input awready,
    output wdata, wvalid, input wready,
    input bid, bresp, bvalid, output bready,
    output arid, araddr, arvalid, input arready,
    input rid, rdata, rresp, rvalid, output rready
  );

  modport slave (
    input awid, awaddr, awvalid, output awready,
    input wdata, wvalid, output wready,
    output bid, bresp, bvalid, input bready,
    input arid, araddr, arvalid, output arready,
    output rid, rdata, rresp, rvalid, input rready
  );
endinterface

// File: rtl/dvp_config_master.sv
// rtl/dvp_config_master.sv - single-outstanding AXI4 register initiator for the DVP config slave; optional CFG_MST_ID_CHECK_EN
module dvp_config_master #(
  parameter int                   DATA_W       = 32,
  parameter int                   ADDR_W       = 32,
  parameter int                   MST_ID_W     = 5,
  parameter logic [MST_ID_W-1:0]  MST_ID       = '0,
  parameter int                   TRANS_RESP_W = 2,
  parameter int                   ERR_CNT_W    = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_cmd_valid,
  output logic                    o_cmd_ready,
  input  logic                    i_cmd_wr,
  input  logic [ADDR_W-1:0]       i_cmd_addr,
  input  logic [DATA_W-1:0]       i_cmd_wdata,
  output logic                    o_rsp_valid,
  input  logic                    i_rsp_ready,
  output logic [DATA_W-1:0]       o_rsp_rdata,
  output logic [TRANS_RESP_W-1:0] o_rsp_resp,
  output logic [ERR_CNT_W-1:0]    o_err_cnt,
  dvp_config_master_if.master     m_axi
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WR_REQ  = 3'd1,
    S_WR_RESP = 3'd2,
    S_RD_REQ  = 3'd3,
    S_RD_RESP = 3'd4,
    S_RSP     = 3'd5
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [ADDR_W-1:0]       r_addr;
  logic [DATA_W-1:0]       r_wdata;
  logic                    r_aw_done;
  logic                    r_w_done;
  logic [DATA_W-1:0]       r_rdata;
  logic [TRANS_RESP_W-1:0] r_resp;
  logic [ERR_CNT_W-1:0]    r_err_cnt;

  logic                    w_capture;
  logic [DATA_W-1:0]       w_cap_data;
  logic [TRANS_RESP_W-1:0] w_cap_resp;
  logic [MST_ID_W-1:0]     w_cap_id;
  logic [TRANS_RESP_W-1:0] w_eff_resp;

  // Next-state and per-state channel strobes; valids depend only on state and sticky flags, never on ready
  always_comb begin
    w_state_nxt     = r_state;
    o_cmd_ready     = 1'b0;
    o_rsp_valid     = 1'b0;
    m_axi.awvalid   = 1'b0;
    m_axi.wvalid    = 1'b0;
    m_axi.bready    = 1'b0;
    m_axi.arvalid   = 1'b0;
    m_axi.rready    = 1'b0;
    w_capture       = 1'b0;
    w_cap_data      = '0;
    w_cap_resp      = '0;
    w_cap_id        = '0;
    case (r_state)
      S_IDLE: begin
        o_cmd_ready = 1'b1;
        if (i_cmd_valid) begin
          w_state_nxt = i_cmd_wr ? S_WR_REQ : S_RD_REQ;
        end
      end
      S_WR_REQ: begin
        m_axi.awvalid = ~r_aw_done;
        m_axi.wvalid  = ~r_w_done;
        if ((r_aw_done | m_axi.awready) && (r_w_done | m_axi.wready)) begin
          w_state_nxt = S_WR_RESP;
        end
      end
      S_WR_RESP: begin
        m_axi.bready = 1'b1;
        if (m_axi.bvalid) begin
          w_capture   = 1'b1;
          w_cap_resp  = m_axi.bresp;
          w_cap_id    = m_axi.bid;
          w_state_nxt = S_RSP;
        end
      end
      S_RD_REQ: begin
        m_axi.arvalid = 1'b1;
        if (m_axi.arready) begin
          w_state_nxt = S_RD_RESP;
        end
      end
      S_RD_RESP: begin
        m_axi.rready = 1'b1;
        if (m_axi.rvalid) begin
          w_capture   = 1'b1;
          w_cap_data  = m_axi.rdata;
          w_cap_resp  = m_axi.rresp;
          w_cap_id    = m_axi.rid;
          w_state_nxt = S_RSP;
        end
      end
      S_RSP: begin
        o_rsp_valid = 1'b1;
        if (i_rsp_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

`ifdef CFG_MST_ID_CHECK_EN
  // A response carrying someone else's ID is reported as SLVERR
  always_comb begin
    w_eff_resp = w_cap_resp;
    if (w_cap_id != MST_ID) begin
      w_eff_resp = TRANS_RESP_W'(2'b10);
    end
  end
`else
  logic w_unused_id;

  // Returned IDs are ignored; the slave's response code passes straight through
  always_comb begin
    w_eff_resp  = w_cap_resp;
    w_unused_id = ^w_cap_id;
  end
`endif

  // State register, command latch, write-handshake flags, response capture and saturating error count
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
      r_rdata   <= '0;
      r_resp    <= '0;
      r_err_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_IDLE && i_cmd_valid) begin
        r_addr    <= i_cmd_addr;
        r_wdata   <= i_cmd_wdata;
        r_aw_done <= 1'b0;
        r_w_done  <= 1'b0;
      end
      if (r_state == S_WR_REQ) begin
        if (m_axi.awready) r_aw_done <= 1'b1;
        if (m_axi.wready)  r_w_done  <= 1'b1;
      end
      if (w_capture) begin
        r_rdata <= w_cap_data;
        r_resp  <= w_eff_resp;
        if (w_eff_resp != '0 && r_err_cnt != '1) begin
          r_err_cnt <= r_err_cnt + ERR_CNT_W'(1);
        end
      end
    end
  end

  assign m_axi.awid   = MST_ID;
  assign m_axi.arid   = MST_ID;
  assign m_axi.awaddr = r_addr;
  assign m_axi.araddr = r_addr;
  assign m_axi.wdata  = r_wdata;
  assign o_rsp_rdata  = r_rdata;
  assign o_rsp_resp   = r_resp;
  assign o_err_cnt    = r_err_cnt;

endmodule

// File: tb/tb_dvp_config_master.sv
// tb/tb_dvp_config_master.sv - directed self-checking bench for dvp_config_master
module tb_dvp_config_master;
  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_wr;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [7:0]  err_cnt;

  int n_assert = 0;
  int n_fail   = 0;

  logic        g_arvalid;
  logic [31:0] g_araddr;
  logic        g_rsp_valid;
  logic [31:0] g_rdata;
  logic [1:0]  g_resp;

  always #5 clk = ~clk;

  dvp_config_master_if #(.DATA_W(32), .ADDR_W(32), .MST_ID_W(5), .TRANS_RESP_W(2)) axi ();

  dvp_config_master #(
    .DATA_W(32), .ADDR_W(32), .MST_ID_W(5), .MST_ID(5'd0), .TRANS_RESP_W(2), .ERR_CNT_W(8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .i_cmd_valid (cmd_valid),
    .o_cmd_ready (cmd_ready),
    .i_cmd_wr    (cmd_wr),
    .i_cmd_addr  (cmd_addr),
    .i_cmd_wdata (cmd_wdata),
    .o_rsp_valid (rsp_valid),
    .i_rsp_ready (rsp_ready),
    .o_rsp_rdata (rsp_rdata),
    .o_rsp_resp  (rsp_resp),
    .o_err_cnt   (err_cnt),
    .m_axi       (axi)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  // Zero-wait read transaction; leaves the block back in IDLE
  task automatic rd_txn(input logic [31:0] addr, input logic [31:0] data,
                        input logic [1:0] resp, input logic [4:0] id);
    cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_addr = addr;
    next_cyc();
    cmd_valid = 1'b0; axi.arready = 1'b1;
    #2;
    g_arvalid = axi.arvalid; g_araddr = axi.araddr;
    next_cyc();
    axi.arready = 1'b0; axi.rvalid = 1'b1; axi.rdata = data; axi.rresp = resp; axi.rid = id;
    next_cyc();
    axi.rvalid = 1'b0;
    #2;
    g_rsp_valid = rsp_valid; g_rdata = rsp_rdata; g_resp = rsp_resp;
    rsp_ready = 1'b1;
    next_cyc();
    rsp_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_addr = '0; cmd_wdata = '0; rsp_ready = 1'b0;
    axi.awready = 1'b0; axi.wready = 1'b0; axi.bvalid = 1'b0; axi.bid = '0; axi.bresp = '0;
    axi.arready = 1'b0; axi.rvalid = 1'b0; axi.rid = '0; axi.rdata = '0; axi.rresp = '0;
    next_cyc();
    next_cyc();
    rst = 1'b0;
    #2;
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_awvalid", axi.awvalid, 0);
    chk("rst_wvalid", axi.wvalid, 0);
    chk("rst_arvalid", axi.arvalid, 0);
    chk("rst_bready", axi.bready, 0);
    chk("rst_rready", axi.rready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_rsp_resp", rsp_resp, 0);
    chk("rst_err_cnt", err_cnt, 0);
    next_cyc();

    // Zero-wait write 0x4000_0004 <= 0x1234
    cmd_valid = 1'b1; cmd_wr = 1'b1; cmd_addr = 32'h4000_0004; cmd_wdata = 32'h0000_1234;
    #2;
    chk("w0_accept_ready", cmd_ready, 1);
    next_cyc();
    cmd_valid = 1'b0; cmd_addr = 32'hFFFF_FFFF; cmd_wdata = 32'hDEAD_BEEF;
    axi.awready = 1'b1; axi.wready = 1'b1;
    #2;
    chk("w0_awvalid_c1", axi.awvalid, 1);
    chk("w0_wvalid_c1", axi.wvalid, 1);
    chk("w0_awaddr", axi.awaddr, 32'h4000_0004);
    chk("w0_wdata", axi.wdata, 32'h0000_1234);
    chk("w0_awid", axi.awid, 0);
    next_cyc();
    axi.awready = 1'b0; axi.wready = 1'b0; axi.bvalid = 1'b1; axi.bresp = 2'b00; axi.bid = 5'd0;
    #2;
    chk("w0_awvalid_c2", axi.awvalid, 0);
    chk("w0_wvalid_c2", axi.wvalid, 0);
    chk("w0_bready_c2", axi.bready, 1);
    chk("w0_rsp_valid_c2", rsp_valid, 0);
    next_cyc();
    axi.bvalid = 1'b0;
    #2;
    chk("w0_rsp_valid_c3", rsp_valid, 1);
    chk("w0_rsp_resp", rsp_resp, 2'b00);
    chk("w0_rsp_rdata", rsp_rdata, 0);
    chk("w0_cmd_ready_rsp", cmd_ready, 0);
    rsp_ready = 1'b1;
    next_cyc();
    rsp_ready = 1'b0;
    #2;
    chk("w0_rsp_valid_done", rsp_valid, 0);
    chk("w0_cmd_ready_idle", cmd_ready, 1);
    next_cyc();

    // Read back 0x4000_0004
    rd_txn(32'h4000_0004, 32'h0000_1234, 2'b00, 5'd0);
    chk("r0_arvalid", g_arvalid, 1);
    chk("r0_araddr", g_araddr, 32'h4000_0004);
    chk("r0_rsp_valid", g_rsp_valid, 1);
    chk("r0_rdata", g_rdata, 32'h0000_1234);
    chk("r0_resp", g_resp, 2'b00);
    chk("r0_err_cnt", err_cnt, 0);

    // Write with W handshake 4 cycles after AW
    cmd_valid = 1'b1; cmd_wr = 1'b1; cmd_addr = 32'h4000_0008; cmd_wdata = 32'h8000_0000;
    next_cyc();
    cmd_valid = 1'b0; axi.awready = 1'b1; axi.wready = 1'b0;
    #2;
    chk("w1_awvalid_c1", axi.awvalid, 1);
    chk("w1_wvalid_c1", axi.wvalid, 1);
    next_cyc();
    axi.awready = 1'b0;
    #2;
    chk("w1_awvalid_drop", axi.awvalid, 0);
    chk("w1_wvalid_c2", axi.wvalid, 1);
    for (int i = 0; i < 2; i++) begin
      next_cyc();
      #2;
      chk("w1_wvalid_hold", axi.wvalid, 1);
      chk("w1_wdata_hold", axi.wdata, 32'h8000_0000);
      chk("w1_bready_early", axi.bready, 0);
    end
    next_cyc();
    axi.wready = 1'b1;
    #2;
    chk("w1_wvalid_c5", axi.wvalid, 1);
    chk("w1_awvalid_c5", axi.awvalid, 0);
    next_cyc();
    axi.wready = 1'b0; axi.bvalid = 1'b1; axi.bresp = 2'b00;
    #2;
    chk("w1_wvalid_drop", axi.wvalid, 0);
    chk("w1_bready", axi.bready, 1);
    next_cyc();
    axi.bvalid = 1'b0;
    #2;
    chk("w1_rsp_valid", rsp_valid, 1);
    chk("w1_bready_after_b", axi.bready, 0);
    chk("w1_resp", rsp_resp, 2'b00);
    rsp_ready = 1'b1;
    next_cyc();
    rsp_ready = 1'b0;

    // W accepted before AW
    cmd_valid = 1'b1; cmd_wr = 1'b1; cmd_addr = 32'h4000_0000; cmd_wdata = 32'h0000_0003;
    next_cyc();
    cmd_valid = 1'b0; axi.wready = 1'b1;
    next_cyc();
    axi.wready = 1'b0; axi.awready = 1'b1;
    #2;
    chk("w2_wvalid_drop", axi.wvalid, 0);
    chk("w2_awvalid_hold", axi.awvalid, 1);
    next_cyc();
    axi.awready = 1'b0; axi.bvalid = 1'b1; axi.bresp = 2'b00;
    #2;
    chk("w2_bready", axi.bready, 1);
    next_cyc();
    axi.bvalid = 1'b0; rsp_ready = 1'b1;
    next_cyc();
    rsp_ready = 1'b0;

    // Unmapped read, then hold the response for 5 cycles with a competing command
    cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_addr = 32'h4000_000C;
    next_cyc();
    cmd_valid = 1'b0; axi.arready = 1'b1;
    #2;
    chk("r1_arvalid", axi.arvalid, 1);
    next_cyc();
    axi.arready = 1'b0; axi.rvalid = 1'b1; axi.rdata = 32'hBAD0_000C; axi.rresp = 2'b11; axi.rid = 5'd0;
    #2;
    chk("r1_rready", axi.rready, 1);
    next_cyc();
    axi.rvalid = 1'b0;
    cmd_valid = 1'b1; cmd_wr = 1'b1; cmd_addr = 32'h4000_0000; cmd_wdata = 32'h0000_0055;
    #2;
    chk("r1_rsp_valid", rsp_valid, 1);
    chk("r1_resp", rsp_resp, 2'b11);
    chk("r1_err_cnt", err_cnt, 1);
    for (int i = 0; i < 5; i++) begin
      next_cyc();
      #2;
      chk("hold_rsp_valid", rsp_valid, 1);
      chk("hold_rsp_rdata", rsp_rdata, 32'hBAD0_000C);
      chk("hold_rsp_resp", rsp_resp, 2'b11);
      chk("hold_cmd_ready", cmd_ready, 0);
      chk("hold_awvalid", axi.awvalid, 0);
    end
    next_cyc();
    cmd_valid = 1'b0; rsp_ready = 1'b1;
    next_cyc();
    rsp_ready = 1'b0;
    #2;
    chk("hold_idle_ready", cmd_ready, 1);
    chk("hold_err_cnt", err_cnt, 1);
    next_cyc();
    #2;
    chk("hold_no_stale_aw", axi.awvalid, 0);
    chk("hold_no_stale_ar", axi.arvalid, 0);
    next_cyc();

    // 260 error reads: counter must stop at 255
    for (int i = 0; i < 260; i++) begin
      rd_txn(32'h4000_000C, 32'h0, 2'b11, 5'd0);
      if (i == 9) chk("sat_err_cnt_11", err_cnt, 11);
    end
    chk("sat_resp", g_resp, 2'b11);
    chk("sat_err_cnt", err_cnt, 255);

    // Reset while waiting for B
    cmd_valid = 1'b1; cmd_wr = 1'b1; cmd_addr = 32'h4000_0004; cmd_wdata = 32'h0000_0077;
    next_cyc();
    cmd_valid = 1'b0; axi.awready = 1'b1; axi.wready = 1'b1;
    next_cyc();
    axi.awready = 1'b0; axi.wready = 1'b0;
    #2;
    chk("rstx_in_wr_resp", axi.bready, 1);
    rst = 1'b1;
    next_cyc();
    rst = 1'b0;
    #2;
    chk("rstx_awvalid", axi.awvalid, 0);
    chk("rstx_wvalid", axi.wvalid, 0);
    chk("rstx_bready", axi.bready, 0);
    chk("rstx_rsp_valid", rsp_valid, 0);
    chk("rstx_cmd_ready", cmd_ready, 1);
    chk("rstx_err_cnt", err_cnt, 0);
    chk("rstx_rsp_resp", rsp_resp, 0);
    next_cyc();

    // Read answered with a foreign ID
    rd_txn(32'h4000_0004, 32'h0000_1234, 2'b00, 5'd3);
    chk("id_rdata", g_rdata, 32'h0000_1234);
`ifdef CFG_MST_ID_CHECK_EN
    chk("id_resp", g_resp, 2'b10);
    chk("id_err_cnt", err_cnt, 1);
`else
    chk("id_resp", g_resp, 2'b00);
    chk("id_err_cnt", err_cnt, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
